// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared types and constants for the remote command link endpoint.
//   cmd_state_t : command assembly FSM states (IDLE, WAIT_LO)
//   rx_state_t  : receiver bit-sampler states
//   FRAME_BITS  : start + 8 data + stop
//   half_bit()  : start-bit mid-sample offset for a given clocks-per-bit value
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

  localparam int FRAME_BITS = 10;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LO = 1'b1
  } cmd_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Integer division on purpose: for odd divisors the start sample lands
  // half a clock early, which still sits well inside the start bit.
  function automatic int half_bit(input int baud_div);
    return baud_div / 2;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver: double-flop synchronizer, start-edge detect, mid-bit
// sampling, stop-bit check.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RX_IDLE  | line idle, waiting for a falling edge on the synchronized RX
// RX_START | counting to the middle of the start bit; a 1 there is a glitch
// RX_DATA  | sampling 8 data bits LSB-first, one per BAUD_DIV clocks
// RX_STOP  | sampling the stop bit; 1 -> byte ready, 0 -> framing error
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_rx         serial input, idle high, asynchronous to i_clk
//   o_rx_data    last good byte (valid with o_rx_rdy)
//   o_rx_rdy     one-cycle pulse: good byte received
//   o_frame_err  one-cycle pulse: stop bit sampled as 0, byte dropped
// -----------------------------------------------------------------------------
module uart_rx
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_rdy,
  output logic       o_frame_err
);

  localparam int BAUD_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BAUD_W-1:0] BIT_RELOAD  = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BAUD_W-1:0] HALF_RELOAD = BAUD_W'(half_bit(BAUD_DIV) - 1);

  rx_state_t         r_state;
  rx_state_t         w_next;
  logic              r_rx_s1;
  logic              r_rx_s2;
  logic              r_rx_prev;
  logic [BAUD_W-1:0] r_baud_cnt;
  logic [3:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic [7:0]        r_rx_data;
  logic              r_rx_rdy;
  logic              r_frame_err;
  logic              w_tick;
  logic              w_stop_good;
  logic              w_stop_bad;

  assign w_tick = (r_baud_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_stop_good = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (r_rx_prev && !r_rx_s2) w_next = RX_START;
      end
      RX_START: begin
        if (w_tick) w_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (w_tick && (r_bit_cnt == 4'd7)) w_next = RX_STOP;
      end
      RX_STOP: begin
        if (w_tick) begin
          w_next      = RX_IDLE;
          w_stop_good = r_rx_s2;
          w_stop_bad  = !r_rx_s2;
        end
      end
      default: w_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_rdy    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_s1     <= i_rx;
      r_rx_s2     <= r_rx_s1;
      r_rx_prev   <= r_rx_s2;
      r_rx_rdy    <= w_stop_good;
      r_frame_err <= w_stop_bad;
      if (w_stop_good) r_rx_data <= r_shift;

      if (r_state == RX_IDLE) begin
        // Preloaded so the first count after the edge lands mid start bit.
        r_baud_cnt <= HALF_RELOAD;
        r_bit_cnt  <= '0;
      end else if (w_tick) begin
        r_baud_cnt <= BIT_RELOAD;
        if (r_state == RX_DATA) begin
          r_shift   <= {r_rx_s2, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else begin
        r_baud_cnt <= r_baud_cnt - BAUD_W'(1);
      end
    end
  end

  assign o_rx_data   = r_rx_data;
  assign o_rx_rdy    = r_rx_rdy;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// -----------------------------------------------------------------------------
// uart_cmd_wrapper
// Knight-side endpoint of the remote command link. Pairs received bytes
// (high then low) into 16-bit commands and serializes 8-bit responses.
//
// state   | meaning
// --------+------------------------------------------------------------------
// IDLE    | next received byte is a command high byte
// WAIT_LO | high byte held; next received byte completes the command
//
// Optional feature macro: CMD_TIMEOUT_EN
//   defined   : WAIT_LO gives up after TIMEOUT_CYC cycles without a low byte
//   undefined : WAIT_LO waits indefinitely, no timeout counter is built
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_rx           serial input from host, idle high
//   o_tx           serial output to host, idle high
//   o_cmd          last assembled command {high, low}
//   o_cmd_rdy      sticky: new command valid on o_cmd
//   i_clr_cmd_rdy  consumer acknowledge, clears o_cmd_rdy
//   i_resp         response byte to send
//   i_trmt         one-cycle transmit request
//   o_tx_done      sticky: last response fully shifted out
//   o_frame_err    one-cycle pulse: received byte had a bad stop bit
// -----------------------------------------------------------------------------
module uart_cmd_wrapper
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV    = 2604,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  output logic        o_tx,
  output logic [15:0] o_cmd,
  output logic        o_cmd_rdy,
  input  logic        i_clr_cmd_rdy,
  input  logic [7:0]  i_resp,
  input  logic        i_trmt,
  output logic        o_tx_done,
  output logic        o_frame_err
);

  localparam int BAUD_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BAUD_W-1:0] BIT_RELOAD = BAUD_W'(BAUD_DIV - 1);
  localparam logic [3:0]        LAST_BIT   = 4'(FRAME_BITS - 1);

  logic [7:0] w_rx_data;
  logic       w_rx_rdy;
  logic       w_frame_err;

  uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx        (i_rx),
    .o_rx_data   (w_rx_data),
    .o_rx_rdy    (w_rx_rdy),
    .o_frame_err (w_frame_err)
  );

  // ---------------------------------------------------------------------------
  // Command assembly
  // ---------------------------------------------------------------------------
  cmd_state_t  r_state;
  cmd_state_t  w_next;
  logic [7:0]  r_hi;
  logic [15:0] r_cmd;
  logic        r_cmd_rdy;
  logic        w_latch_hi;
  logic        w_load_cmd;
  logic        w_timeout;

`ifdef CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Held at zero outside WAIT_LO, so it always starts from 0 on entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_to_cnt <= '0;
    end else if (r_state != WAIT_LO) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign w_timeout = (r_state == WAIT_LO) && (r_to_cnt == TO_W'(TIMEOUT_CYC));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_latch_hi = 1'b0;
    w_load_cmd = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rx_rdy) begin
          w_latch_hi = 1'b1;
          w_next     = WAIT_LO;
        end
      end
      WAIT_LO: begin
        // A low byte arriving on the timeout cycle still completes the command.
        if (w_rx_rdy) begin
          w_load_cmd = 1'b1;
          w_next     = IDLE;
        end else if (w_timeout) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi      <= '0;
      r_cmd     <= '0;
      r_cmd_rdy <= 1'b0;
    end else begin
      if (w_latch_hi) r_hi  <= w_rx_data;
      if (w_load_cmd) r_cmd <= {r_hi, w_rx_data};
      // Set has priority over an acknowledge in the same cycle.
      if (w_load_cmd) begin
        r_cmd_rdy <= 1'b1;
      end else if (w_latch_hi || i_clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response serializer
  // ---------------------------------------------------------------------------
  logic              r_tx_busy;
  logic              r_tx;
  logic [8:0]        r_tx_shift;
  logic [BAUD_W-1:0] r_tx_baud;
  logic [3:0]        r_tx_bit;
  logic              r_tx_done;

  // The start bit goes straight to r_tx; r_tx_shift holds the remaining
  // data bits plus the stop bit, refilled with 1s as it drains.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_busy  <= 1'b0;
      r_tx       <= 1'b1;
      r_tx_shift <= '1;
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
      r_tx_done  <= 1'b0;
    end else if (!r_tx_busy) begin
      if (i_trmt) begin
        r_tx_busy  <= 1'b1;
        r_tx       <= 1'b0;
        r_tx_shift <= {1'b1, i_resp};
        r_tx_baud  <= BIT_RELOAD;
        r_tx_bit   <= '0;
        r_tx_done  <= 1'b0;
      end
    end else if (r_tx_baud != '0) begin
      r_tx_baud <= r_tx_baud - BAUD_W'(1);
    end else if (r_tx_bit == LAST_BIT) begin
      r_tx_busy <= 1'b0;
      r_tx      <= 1'b1;
      r_tx_done <= 1'b1;
    end else begin
      r_tx       <= r_tx_shift[0];
      r_tx_shift <= {1'b1, r_tx_shift[8:1]};
      r_tx_bit   <= r_tx_bit + 4'd1;
      r_tx_baud  <= BIT_RELOAD;
    end
  end

  assign o_tx        = r_tx;
  assign o_cmd       = r_cmd;
  assign o_cmd_rdy   = r_cmd_rdy;
  assign o_tx_done   = r_tx_done;
  assign o_frame_err = w_frame_err;

endmodule
